// File: rtl/seq_mult_param.sv
// rtl/seq_mult_param.sv - parametrised sequential shift-add multiplier
//
// Purpose:
//    WIDTH x WIDTH -> 2*WIDTH shift-add multiplier. The product builds up in
//    {A,B}, and X is the extension/carry bit above A. Signed operation uses
//    two's complement, with a subtract on the final step. Unsigned operation
//    uses X as the carry out of the add.
//
// Ports:
//    Clk           in   clock; all state updates on the rising edge
//    Reset         in   synchronous, active-high reset
//    Run           in   start request; level sampled in IDLE, must drop to re-arm
//    ClearA_LoadB  in   in IDLE: A<=0, X<=0, B<=S (takes priority over Run)
//    S             in   multiplicand; must be stable while Busy
//    Aval          out  register A (product upper half)
//    Bval          out  register B (multiplier, then product lower half)
//    X             out  sign-extension (signed) or carry (unsigned) bit
//    P             out  {Aval,Bval}
//    Busy          out  high in CLR/ADD/SHIFT
//    Done          out  high in DONE

module seq_mult_param #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Run,
   input  logic                 ClearA_LoadB,
   input  logic [WIDTH-1:0]     S,
   output logic [WIDTH-1:0]     Aval,
   output logic [WIDTH-1:0]     Bval,
   output logic                 X,
   output logic [2*WIDTH-1:0]   P,
   output logic                 Busy,
   output logic                 Done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_ADD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              x_q;
   logic [CW-1:0]     cnt;

   logic [WIDTH:0]    aug;
   logic [WIDTH:0]    addend;
   logic [WIDTH:0]    sum;

   // A WIDTH+1 bit adder is wide enough for the sum or difference of two
   // extended operands. The signed multiplier's MSB carries negative weight,
   // so the last partial product is subtracted.
   always_comb begin
      aug    = (SIGNED != 0) ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
      addend = (SIGNED != 0) ? {S[WIDTH-1], S}     : {1'b0, S};
      if ((SIGNED != 0) && (cnt == LAST))
         sum = aug - addend;
      else
         sum = aug + addend;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= ST_IDLE;
         a_q   <= '0;
         b_q   <= '0;
         x_q   <= 1'b0;
         cnt   <= '0;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ClearA_LoadB) begin
                  a_q <= '0;
                  x_q <= 1'b0;
                  b_q <= S;
               end else if (Run) begin
                  state <= ST_CLR;
                  Busy  <= 1'b1;
               end
            end
            ST_CLR: begin
               a_q   <= '0;
               x_q   <= 1'b0;
               cnt   <= '0;
               state <= ST_ADD;
            end
            ST_ADD: begin
               if (b_q[0])
                  {x_q, a_q} <= sum;
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               // In signed mode X is the sign, so it replicates into A's MSB.
               a_q <= {x_q, a_q[WIDTH-1:1]};
               b_q <= {a_q[0], b_q[WIDTH-1:1]};
               if (SIGNED == 0)
                  x_q <= 1'b0;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= ST_DONE;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else begin
                  state <= ST_ADD;
               end
            end
            ST_DONE: begin
               if (!Run) begin
                  state <= ST_IDLE;
                  Done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

   assign Aval = a_q;
   assign Bval = b_q;
   assign X    = x_q;
   assign P    = {a_q, b_q};

endmodule

// File: tb/tb_seq_mult_param.sv
// tb/tb_seq_mult_param.sv - directed bench for seq_mult_param (8-bit signed, 8-bit unsigned, 4-bit signed)

module tb_seq_mult_param;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       ClearA_LoadB;
   logic [7:0] S;
   logic       run_s8, run_u8, run_s4;

   logic [7:0]  a_s8, b_s8, a_u8, b_u8;
   logic [3:0]  a_s4, b_s4;
   logic [15:0] p_s8, p_u8;
   logic [7:0]  p_s4;
   logic        x_s8, x_u8, x_s4;
   logic        busy_s8, busy_u8, busy_s4;
   logic        done_s8, done_u8, done_s4;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   seq_mult_param #(.WIDTH(8), .SIGNED(1)) u_s8 (
      .Clk(Clk), .Reset(Reset), .Run(run_s8), .ClearA_LoadB(ClearA_LoadB), .S(S),
      .Aval(a_s8), .Bval(b_s8), .X(x_s8), .P(p_s8), .Busy(busy_s8), .Done(done_s8));

   seq_mult_param #(.WIDTH(8), .SIGNED(0)) u_u8 (
      .Clk(Clk), .Reset(Reset), .Run(run_u8), .ClearA_LoadB(ClearA_LoadB), .S(S),
      .Aval(a_u8), .Bval(b_u8), .X(x_u8), .P(p_u8), .Busy(busy_u8), .Done(done_u8));

   seq_mult_param #(.WIDTH(4), .SIGNED(1)) u_s4 (
      .Clk(Clk), .Reset(Reset), .Run(run_s4), .ClearA_LoadB(ClearA_LoadB), .S(S[3:0]),
      .Aval(a_s4), .Bval(b_s4), .X(x_s4), .P(p_s4), .Busy(busy_s4), .Done(done_s4));

   // sel: 0 = 8-bit signed, 1 = 8-bit unsigned, 2 = 4-bit signed
   function automatic logic [15:0] p_of(input int sel);
      case (sel)
         0:       return p_s8;
         1:       return p_u8;
         default: return {8'h00, p_s4};
      endcase
   endfunction

   function automatic logic [15:0] ab_of(input int sel);
      case (sel)
         0:       return {a_s8, b_s8};
         1:       return {a_u8, b_u8};
         default: return {8'h00, a_s4, b_s4};
      endcase
   endfunction

   function automatic logic x_of(input int sel);
      case (sel)
         0:       return x_s8;
         1:       return x_u8;
         default: return x_s4;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return busy_s8;
         1:       return busy_u8;
         default: return busy_s4;
      endcase
   endfunction

   function automatic logic done_of(input int sel);
      case (sel)
         0:       return done_s8;
         1:       return done_u8;
         default: return done_s4;
      endcase
   endfunction

   task automatic set_run(input int sel, input logic v);
      case (sel)
         0:       run_s8 = v;
         1:       run_u8 = v;
         default: run_s4 = v;
      endcase
   endtask

   // Optionally loads B, raises Run, then waits (bounded) for Done.
   // last_edge is the index of the edge after which Done was first seen (edge 0 samples Run).
   task automatic do_mult(input int sel, input bit load, input logic [7:0] b, input logic [7:0] s,
                          output int last_edge, output bit busy_ok, output bit timeout);
      @(negedge Clk);
      if (load) begin
         ClearA_LoadB = 1'b1;
         S = b;
         @(negedge Clk);
         ClearA_LoadB = 1'b0;
      end
      S = s;
      set_run(sel, 1'b1);
      last_edge = -1;
      busy_ok = 1'b1;
      do begin
         @(negedge Clk);
         last_edge++;
         if (!done_of(sel) && !busy_of(sel)) busy_ok = 1'b0;
      end while (!done_of(sel) && last_edge < 200);
      if (busy_of(sel)) busy_ok = 1'b0;
      timeout = !done_of(sel);
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      ClearA_LoadB = 1'b0;
      S = 8'h00;
      run_s8 = 1'b0; run_u8 = 1'b0; run_s4 = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
         total++;
         if ({p_of(i), ab_of(i), x_of(i), busy_of(i), done_of(i)} !== 35'h0) begin
            bad++;
            $display("FAIL reset dut%0d: P=%h AB=%h X=%b Busy=%b Done=%b required all zero",
                     i, p_of(i), ab_of(i), x_of(i), busy_of(i), done_of(i));
         end
      end
   endtask

   typedef struct {
      int          sel;
      logic [7:0]  b;
      logic [7:0]  s;
      logic [15:0] p;
      logic        x;
   } vec_t;

   task automatic test_products;
      vec_t vecs [14];
      int   le, lat;
      bit   bok, tmo;
      vecs = '{
         '{0, 8'hC5, 8'h07, 16'hFE63, 1'b1},
         '{0, 8'h80, 8'h80, 16'h4000, 1'b0},
         '{0, 8'h80, 8'h00, 16'h0000, 1'b0},
         '{0, 8'h00, 8'h55, 16'h0000, 1'b0},
         '{0, 8'h7F, 8'h7F, 16'h3F01, 1'b0},
         '{0, 8'h7F, 8'h80, 16'hC080, 1'b1},
         '{0, 8'hFF, 8'hFF, 16'h0001, 1'b0},
         '{0, 8'h03, 8'hFB, 16'hFFF1, 1'b1},
         '{1, 8'hFF, 8'hFF, 16'hFE01, 1'b0},
         '{1, 8'hC5, 8'h07, 16'h0563, 1'b0},
         '{1, 8'h80, 8'h80, 16'h4000, 1'b0},
         '{2, 8'h08, 8'h07, 16'h00C8, 1'b1},
         '{2, 8'h08, 8'h08, 16'h0040, 1'b0},
         '{2, 8'h05, 8'h0D, 16'h00F1, 1'b1}
      };
      for (int i = 0; i < 14; i++) begin
         lat = (vecs[i].sel == 2) ? 9 : 17;
         do_mult(vecs[i].sel, 1'b1, vecs[i].b, vecs[i].s, le, bok, tmo);
         total++;
         if (tmo || le != lat) begin
            bad++;
            $display("FAIL latency vec%0d: done after edge %0d (timeout=%b) required %0d", i, le, tmo, lat);
         end
         total++;
         if (!bok) begin
            bad++;
            $display("FAIL busy vec%0d: Busy not high throughout run / low at Done", i);
         end
         total++;
         if (p_of(vecs[i].sel) !== vecs[i].p) begin
            bad++;
            $display("FAIL product vec%0d: P=%h required %h", i, p_of(vecs[i].sel), vecs[i].p);
         end
         total++;
         if (x_of(vecs[i].sel) !== vecs[i].x) begin
            bad++;
            $display("FAIL xbit vec%0d: X=%b required %b", i, x_of(vecs[i].sel), vecs[i].x);
         end
         set_run(vecs[i].sel, 1'b0);
         @(negedge Clk);
      end
   endtask

   task automatic test_hold_and_rerun;
      int le;
      bit bok, tmo, stable;
      do_mult(0, 1'b1, 8'h03, 8'h05, le, bok, tmo);
      total++;
      if (tmo || p_s8 !== 16'h000F) begin
         bad++;
         $display("FAIL hold_first: P=%h timeout=%b required 000f", p_s8, tmo);
      end
      stable = 1'b1;
      repeat (10) begin
         @(negedge Clk);
         if (!done_s8 || p_s8 !== 16'h000F) stable = 1'b0;
      end
      total++;
      if (!stable) begin
         bad++;
         $display("FAIL hold_stable: Done=%b P=%h required Done=1 P=000f", done_s8, p_s8);
      end
      run_s8 = 1'b0;
      @(negedge Clk);
      total++;
      if (done_s8 !== 1'b0 || busy_s8 !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: Done=%b Busy=%b required 0 0", done_s8, busy_s8);
      end
      // No reload: the previous low half 0x0F is the new multiplier.
      do_mult(0, 1'b0, 8'h00, 8'h05, le, bok, tmo);
      total++;
      if (tmo || le != 17 || p_s8 !== 16'h004B) begin
         bad++;
         $display("FAIL rerun: P=%h edge=%0d timeout=%b required 004b at 17", p_s8, le, tmo);
      end
      run_s8 = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_load_ignored;
      int n;
      @(negedge Clk);
      ClearA_LoadB = 1'b1;
      S = 8'hC5;
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
      S = 8'h07;
      run_s8 = 1'b1;
      repeat (5) @(negedge Clk);
      ClearA_LoadB = 1'b1;
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
      n = 0;
      while (!done_s8 && n < 100) begin
         @(negedge Clk);
         n++;
      end
      total++;
      if (!done_s8 || p_s8 !== 16'hFE63) begin
         bad++;
         $display("FAIL load_ignored: Done=%b P=%h required 1 fe63", done_s8, p_s8);
      end
      run_s8 = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_reset_midrun;
      bit idle_ok;
      @(negedge Clk);
      ClearA_LoadB = 1'b1;
      S = 8'hC5;
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
      S = 8'h07;
      run_s8 = 1'b1;
      repeat (5) @(negedge Clk);
      Reset = 1'b1;
      run_s8 = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
      total++;
      if ({p_s8, x_s8, busy_s8, done_s8} !== 19'h0) begin
         bad++;
         $display("FAIL reset_midrun: P=%h X=%b Busy=%b Done=%b required all zero",
                  p_s8, x_s8, busy_s8, done_s8);
      end
      idle_ok = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         if (busy_s8 || done_s8 || p_s8 !== 16'h0) idle_ok = 1'b0;
      end
      total++;
      if (!idle_ok) begin
         bad++;
         $display("FAIL reset_idle: Busy=%b Done=%b P=%h required 0 0 0000", busy_s8, done_s8, p_s8);
      end
   endtask

   initial begin
      test_reset;
      test_products;
      test_hold_and_rerun;
      test_load_ignored;
      test_reset_midrun;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
